// File: rtl/divide_sequencer.sv
// Multi-cycle radix-2 restoring divider with its own sequencing FSM.
// Signed operands run on magnitudes; signs are restored in a fix-up cycle.
module divide_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divide_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITERATE,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             is_signed_q, is_signed_d;
    logic [WIDTH-1:0] numer_q, numer_d;
    logic [WIDTH-1:0] denom_q, denom_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             numer_neg;
    logic             denom_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d     = state_q;
        is_signed_d = is_signed_q;
        numer_d     = numer_q;
        denom_d     = denom_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        numer_neg = is_signed_q & numer_q[WIDTH-1];
        denom_neg = is_signed_q & denom_q[WIDTH-1];
        // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial.
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    is_signed_d = is_signed;
                    numer_d     = numer;
                    denom_d     = denom;
                    state_d     = PREP;
                end
            end
            PREP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (denom_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = numer_q;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    dvd_d    = numer_neg ? -numer_q : numer_q;
                    dvs_d    = denom_neg ? -denom_q : denom_q;
                    sign_q_d = numer_neg ^ denom_neg;
                    sign_r_d = numer_neg;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = ITERATE;
                end
            end
            ITERATE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    quotient_d  = sign_q_q ? -dvd_q : dvd_q;
                    remainder_d = sign_r_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            is_signed_q <= 1'b0;
            numer_q     <= '0;
            denom_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_signed_q <= is_signed_d;
            numer_q     <= numer_d;
            denom_q     <= denom_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy = (state_q == PREP) || (state_q == ITERATE) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign quotient       = quotient_q;
    assign remainder      = remainder_q;
    assign divide_by_zero = dbz_q;

endmodule

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: arithmetic reference model plus
// directed vectors with hand-computed results and latencies.
module tb_divide_sequencer;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] numer = '0;
    logic [W-1:0] denom = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divide_by_zero;

    divide_sequencer #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .is_signed      (is_signed),
        .numer          (numer),
        .denom          (denom),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .quotient       (quotient),
        .remainder      (remainder),
        .divide_by_zero (divide_by_zero)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    function automatic res_t calc(input logic [W-1:0] n, input logic [W-1:0] d,
                                  input logic s);
        res_t res;
        logic signed [W-1:0] sn;
        logic signed [W-1:0] sd;
        sn = n;
        sd = d;
        res.z = 1'b0;
        if (d == '0) begin
            res.q = '1;
            res.r = n;
            res.z = 1'b1;
        end else if (s && n == MINV && d == '1) begin
            res.q = MINV;
            res.r = '0;
        end else if (s) begin
            res.q = sn / sd;
            res.r = sn % sd;
        end else begin
            res.q = n / d;
            res.r = n % d;
        end
        return res;
    endfunction

    // Model: an accepted request finishes a fixed number of cycles later.
    bit   m_act = 1'b0;
    int   m_age = 0;
    int   m_lat = 0;
    res_t m_pend = '0;
    res_t m_out = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_act <= 1'b0;
            m_age <= 0;
            m_lat <= 0;
            m_out <= '0;
        end else if (m_act) begin
            if (m_age == m_lat || abort) begin
                m_act <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 == m_lat) m_out <= m_pend;
            end
        end else if (start && !abort) begin
            m_act  <= 1'b1;
            m_age  <= 1;
            m_lat  <= (denom == '0) ? 2 : W + 3;
            m_pend <= calc(numer, denom, is_signed);
        end
    end

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            cmp("busy", {31'b0, busy}, {31'b0, m_act && (m_age < m_lat)});
            cmp("done", {31'b0, done}, {31'b0, m_act && (m_age == m_lat)});
            cmp("quotient", quotient, m_out.q);
            cmp("remainder", remainder, m_out.r);
            cmp("dbz", {31'b0, divide_by_zero}, {31'b0, m_out.z});
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                          output int c0);
        numer = n;
        denom = d;
        is_signed = s;
        start = 1'b1;
        c0 = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int exp_lat, input string nm);
        int k;
        k = 0;
        while (!done && k < 100) begin
            tick;
            k++;
        end
        cmp({nm, "_done_seen"}, {31'b0, done}, 32'd1);
        cmp({nm, "_latency"}, cyc - c0, exp_lat);
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int elat);
        int c0;
        res_t m;
        m = calc(n, d, s);
        cmp({nm, "_model_q"}, m.q, eq);
        cmp({nm, "_model_r"}, m.r, er);
        launch(n, d, s, c0);
        wait_done(c0, elat, nm);
        cmp({nm, "_q"}, quotient, eq);
        cmp({nm, "_r"}, remainder, er);
        cmp({nm, "_dbz"}, {31'b0, divide_by_zero}, {31'b0, ez});
        tick;
    endtask

    initial begin
        int c0;
        repeat (3) tick;
        chk_en = 1'b1;
        cmp("reset_busy", {31'b0, busy}, 32'd0);
        cmp("reset_done", {31'b0, done}, 32'd0);
        cmp("reset_q", quotient, 32'd0);
        cmp("reset_r", remainder, 32'd0);
        cmp("reset_dbz", {31'b0, divide_by_zero}, 32'd0);
        reset = 1'b0;
        tick;

        do_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35);
        do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35);
        do_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 35);
        do_op("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 35);
        do_op("dbz", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 2);
        do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 35);
        do_op("s_dbz", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);
        do_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 35);
        do_op("u_5_7", 32'd5, 32'd7, 1'b0, 32'd0, 32'd5, 1'b0, 35);
        do_op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 35);
        do_op("u100_7b", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35);

        // Second start while busy is dropped.
        launch(32'd100, 32'd7, 1'b0, c0);
        while (cyc < c0 + 5) tick;
        numer = 32'd50;
        denom = 32'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(c0, 35, "contend");
        cmp("contend_q", quotient, 32'd14);
        cmp("contend_r", remainder, 32'd2);
        tick;

        // Abort mid-iteration, then restart immediately.
        launch(32'd50, 32'd5, 1'b0, c0);
        while (cyc < c0 + 10) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        cmp("abort_busy", {31'b0, busy}, 32'd0);
        cmp("abort_q_kept", quotient, 32'd14);
        cmp("abort_r_kept", remainder, 32'd2);
        numer = 32'd40;
        denom = 32'd6;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(c0, 46, "restart");
        cmp("restart_q", quotient, 32'd6);
        cmp("restart_r", remainder, 32'd4);
        tick;

        // Abort together with start in IDLE.
        numer = 32'd9;
        denom = 32'd3;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        cmp("abort_start_busy", {31'b0, busy}, 32'd0);
        repeat (3) tick;

        // Abort in the fix-up cycle must leave outputs alone.
        launch(32'd9, 32'd2, 1'b0, c0);
        while (cyc < c0 + 34) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        cmp("abort_fix_done", {31'b0, done}, 32'd0);
        cmp("abort_fix_q", quotient, 32'd6);
        cmp("abort_fix_r", remainder, 32'd4);
        repeat (4) tick;

        // Abort in the DONE cycle does not suppress the pulse.
        launch(32'd100, 32'd7, 1'b0, c0);
        wait_done(c0, 35, "abort_done");
        abort = 1'b1;
        tick;
        abort = 1'b0;
        cmp("abort_done_idle", {31'b0, busy | done}, 32'd0);
        cmp("abort_done_q", quotient, 32'd14);
        tick;

        // Reset in the middle of iteration.
        launch(32'd1000, 32'd3, 1'b0, c0);
        while (cyc < c0 + 20) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        cmp("rst_mid_busy", {31'b0, busy}, 32'd0);
        cmp("rst_mid_done", {31'b0, done}, 32'd0);
        cmp("rst_mid_q", quotient, 32'd0);
        cmp("rst_mid_r", remainder, 32'd0);
        do_op("after_rst", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 35);

        repeat (2) tick;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
